rom_arbiter: RTL
================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, requester and ROM address width.
REQ-002 Parameter DATA_W, 8, ROM data width.
REQ-003 Parameter LOCK_MAX, 16, maximum consecutive locked grants to one requester (range 1..255).
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock shared with the synchronous ROM.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req0/req1  input  1  access request; held with addr until ack.
REQ-008 lock0/lock1  input  1  burst hint; keeps the grant on the same requester while asserted.
REQ-009 addr0/addr1  input  ADDR_W  requested ROM address.
REQ-010 ack0/ack1  output  1  combinational; request accepted this cycle.
REQ-011 rvalid0/rvalid1  output  1  registered single-cycle pulse; rdata valid.
REQ-012 rdata0/rdata1  output  DATA_W  registered read data, held until the next rvalid of the same port.
REQ-013 rom_a  output  ADDR_W  address to the ROM, which registers dout one clk later.
REQ-014 rom_dout  input  DATA_W  ROM read data.

Function
REQ-015 At most one ack per cycle; ack_i is asserted only when req_i is high.
REQ-016 rom_a equals the winner's addr in its ack cycle; with no winner, rom_a holds its previous value.
REQ-017 Latency: ack in cycle N, rom_dout valid in N+1, rvalid_i and rdata_i in N+2; full throughput of one access per cycle.
REQ-018 The pipeline carries a 2-stage valid+ID shift register; rvalid is routed only to the ID that was acked.
REQ-019 Round-robin: when both req are high, the requester not granted most recently wins; a single requester wins immediately.
REQ-020 Lock: if lock_i and req_i are high and i won the previous cycle, i wins again regardless of RR, subject to REQ-021.
REQ-021 The lock counter increments per locked re-grant; at LOCK_MAX consecutive grants, if the other requester is waiting, it wins the next cycle and the counter clears.
REQ-022 The lock counter clears on any grant to the other requester, on any idle cycle, or when lock_i drops.
REQ-023 Dropping req while not acked is permitted; no ack or rvalid results.
REQ-024 Address wrap: addresses are passed unmodified; ROM decoding of upper bits is outside this block.

Reset
REQ-025 While rst_n is low: ack0/1=0, rvalid0/1=0, rdata0/1=0, rom_a=0, pipeline valids=0, lock counter=0, RR pointer favours requester 0.
REQ-026 Reset asserted mid-access discards the in-flight results; no rvalid is issued after release for any pre-reset ack.
REQ-027 The first acceptance is possible in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro ROM_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins over requester 1 and lock applies to requester 1 only; when undefined, REQ-019..REQ-022 apply as written.

Structure
REQ-029 Package rom_arb_pkg holds ADDR_W/DATA_W defaults, the requester-ID type (1 bit) and LOCK_MAX default.
REQ-030 Sub-module rom_arb_sel holds the winner-selection logic (RR pointer, lock counter, fixed-priority option); the top level holds the address mux and the data pipeline.

Verification (ROM model: mem[a]=a[7:0]^8'h5A, 1-cycle registered read)
REQ-031 req0 alone, addr0=14'h0010 -> ack0 in cycle N, rvalid0 in N+2, rdata0=8'h4A; rvalid1 never asserted.
REQ-032 req0 and req1 held for 4 cycles, addr0=0x0001, addr1=0x0002 -> acks alternate 0,1,0,1 starting with 0; rdata0=8'h5B, rdata1=8'h58.
REQ-033 req1+lock1 held, req0 held, LOCK_MAX=4 -> requester 1 takes 4 consecutive acks, then ack0 occurs, then the order resumes.
REQ-034 Back-to-back req0 with addresses 0..7 -> 8 consecutive acks and 8 consecutive rvalid0 pulses with data i^8'h5A in order.
REQ-035 rst_n pulled low one cycle after ack1 -> all outputs 0 and no rvalid1 after release; next req0 is acked in the first post-reset cycle.
REQ-036 ROM_ARB_FIXED_PRIO_EN defined, both req held 3 cycles -> ack0 in all 3 cycles, ack1 never.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared defaults and types for the two-port ROM arbiter.
package rom_arb_pkg;
  localparam int ADDR_W_DEF   = 14;
  localparam int DATA_W_DEF   = 8;
  localparam int LOCK_MAX_DEF = 16;

  typedef logic rid_t;
endpackage

// File: rtl/rom_arb_sel.sv
// Winner selection: round-robin with lock bursts capped at LOCK_MAX.
// ROM_ARB_FIXED_PRIO_EN: requester 0 has priority, and only requester 1 may lock.
module rom_arb_sel
  import rom_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic       gnt,
  output rid_t       gnt_id
);
  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  // prev_id is also the round-robin pointer; its reset value of 1 favours requester 0.
  logic       prev_vld;
  rid_t       prev_id;
  logic [7:0] cnt;
  logic       hold;

  always_comb begin
`ifdef ROM_ARB_FIXED_PRIO_EN
    hold = prev_vld && prev_id && req[1] && lock[1] && !(cnt >= LMAX && req[0]);
`else
    hold = prev_vld && req[prev_id] && lock[prev_id] && !(cnt >= LMAX && req[~prev_id]);
`endif
    gnt    = rst_n & (|req);
    gnt_id = rid_t'(req[1]);
    if (hold)
      gnt_id = prev_id;
    else if (&req)
`ifdef ROM_ARB_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~prev_id;
`endif
  end

  // cnt counts consecutive grants to the current owner. A new owner restarts it at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      prev_id  <= 1'b1;
      cnt      <= '0;
    end else begin
      prev_vld <= gnt;
      if (gnt) begin
        prev_id <= gnt_id;
        if (prev_vld && gnt_id == prev_id && lock[gnt_id])
          cnt <= (cnt >= LMAX) ? LMAX : cnt + 8'd1;
        else
          cnt <= 8'd1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a 1-cycle registered ROM; read data returns 2 cycles after ack.
// ROM_ARB_FIXED_PRIO_EN selects fixed priority. Its logic is in rom_arb_sel.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_dout
);
  localparam int STAGES = 2;

  logic              gnt;
  rid_t              gnt_id;
  logic [ADDR_W-1:0] addr_q;
  logic [STAGES:1]   vld_pipe;
  rid_t [STAGES:1]   id_pipe;

  rom_arb_sel #(.LOCK_MAX(LOCK_MAX)) u_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .lock   ({lock1, lock0}),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign ack0    = gnt & ~gnt_id;
  assign ack1    = gnt & gnt_id;
  assign rom_a   = gnt ? (gnt_id ? addr1 : addr0) : addr_q;
  assign rvalid0 = vld_pipe[STAGES] & ~id_pipe[STAGES];
  assign rvalid1 = vld_pipe[STAGES] & id_pipe[STAGES];

  // Stage 1 lines up with rom_dout. Stage 2 holds the registered return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      addr_q   <= rom_a;
      vld_pipe <= {vld_pipe[STAGES-1:1], gnt};
      id_pipe  <= {id_pipe[STAGES-1:1], gnt_id};
      if (vld_pipe[STAGES-1] && !id_pipe[STAGES-1]) rdata0 <= rom_dout;
      if (vld_pipe[STAGES-1] &&  id_pipe[STAGES-1]) rdata1 <= rom_dout;
    end
  end
endmodule
